// File: rtl/ffn_pkg.sv
// Shared definitions for the FFN multiply-accumulate engine: width defaults,
// FSM state encoding and lane-slice helper.
package ffn_pkg;

  localparam int FFN_IN_W  = 24;
  localparam int FFN_OUT_W = 58;
  localparam int FFN_LANES = 4;

  typedef enum logic [1:0] {
    FFN_MAC_IDLE = 2'd0,
    FFN_MAC_ACC  = 2'd1,
    FFN_MAC_DONE = 2'd2
  } ffn_mac_state_e;

  // Bit offset of lane `lane` inside a flat bus of `width`-bit lanes.
  function automatic int ffn_lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ffn_mac_array_if.sv
// Feature/weight input stream and per-lane result stream of ffn_mac_array.
// The master modport is the upstream/downstream side, slave is the engine.
interface ffn_mac_array_if #(
  parameter int IN_W  = ffn_pkg::FFN_IN_W,
  parameter int OUT_W = ffn_pkg::FFN_OUT_W,
  parameter int LANES = ffn_pkg::FFN_LANES
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [IN_W-1:0]        feature_pixel;
  logic [LANES*IN_W-1:0]  weight;
  logic [LANES*OUT_W-1:0] bias;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] sum_b;

  modport master (
    output in_valid, feature_pixel, weight, bias, out_ready,
    input  in_ready, out_valid, sum_b
  );

  modport slave (
    input  in_valid, feature_pixel, weight, bias, out_ready,
    output in_ready, out_valid, sum_b
  );

endinterface

// File: rtl/ffn_mac_lane.sv
// One neuron lane: signed multiply, accumulate-or-load, bias latch and the
// registered bias add. Defining FFN_MAC_RELU_EN clamps negative results to 0.
module ffn_mac_lane #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 58
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic                    acc_en_i,
  input  logic                    capture_i,
  input  logic signed [IN_W-1:0]  pixel_i,
  input  logic signed [IN_W-1:0]  weight_i,
  input  logic signed [OUT_W-1:0] bias_i,
  output logic signed [OUT_W-1:0] sum_o
);

  logic signed [2*IN_W-1:0] prod;
  logic signed [OUT_W-1:0]  prod_ext;
  logic signed [OUT_W-1:0]  acc_d, acc_q;
  logic signed [OUT_W-1:0]  bias_sel, bias_q;
  logic signed [OUT_W-1:0]  sum_d, sum_q;

  function automatic logic signed [OUT_W-1:0] relu_clamp(input logic signed [OUT_W-1:0] v);
`ifdef FFN_MAC_RELU_EN
    return v[OUT_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign prod     = pixel_i * weight_i;
  assign prod_ext = OUT_W'(prod);

  // The first beat of a vector restarts the sum and uses the live bias, so the
  // result is correct even when the vector is a single beat long.
  assign acc_d    = load_i ? prod_ext : acc_q + prod_ext;
  assign bias_sel = load_i ? bias_i : bias_q;
  assign sum_d    = acc_d + bias_sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      bias_q <= '0;
      sum_q  <= '0;
    end else begin
      if (acc_en_i)  acc_q  <= acc_d;
      if (load_i)    bias_q <= bias_i;
      if (capture_i) sum_q  <= relu_clamp(sum_d);
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/ffn_mac_array.sv
// LANES-wide dot-product engine for the FFN layer: counts VEC_LEN beats per
// vector, adds per-lane bias and holds the result under valid/ready.
module ffn_mac_array
  import ffn_pkg::*;
#(
  parameter int IN_W    = FFN_IN_W,
  parameter int OUT_W   = FFN_OUT_W,
  parameter int LANES   = FFN_LANES,
  parameter int VEC_LEN = 784
) (
  input  logic          clock,
  input  logic          reset,
  ffn_mac_array_if.slave bus,
  output logic          busy
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN);

  if (OUT_W < 2 * IN_W) begin : g_bad_out_w
    $error("ffn_mac_array: OUT_W must be at least 2*IN_W");
  end
  if (VEC_LEN < 1) begin : g_bad_vec_len
    $error("ffn_mac_array: VEC_LEN must be at least 1");
  end

  ffn_mac_state_e         state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic                   beat, first_beat, last_beat;
  logic signed [OUT_W-1:0] lane_sum [LANES];

  assign bus.in_ready = (state_q != FFN_MAC_DONE) || bus.out_ready;
  assign beat         = bus.in_valid && bus.in_ready;
  // Any beat outside ACC opens a vector, including one that coincides with
  // the result being consumed in DONE.
  assign first_beat   = beat && (state_q != FFN_MAC_ACC);
  assign last_beat    = beat && (first_beat ? (VEC_LEN == 1)
                                            : (count_q == LAST_CNT - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      FFN_MAC_IDLE: begin
        if (beat) begin
          count_d = CNT_W'(1);
          state_d = last_beat ? FFN_MAC_DONE : FFN_MAC_ACC;
        end
      end
      FFN_MAC_ACC: begin
        if (beat) begin
          count_d = count_q + CNT_W'(1);
          if (last_beat) state_d = FFN_MAC_DONE;
        end
      end
      FFN_MAC_DONE: begin
        if (bus.out_ready) begin
          if (beat) begin
            count_d = CNT_W'(1);
            state_d = last_beat ? FFN_MAC_DONE : FFN_MAC_ACC;
          end else begin
            count_d = '0;
            state_d = FFN_MAC_IDLE;
          end
        end
      end
      default: begin
        count_d = '0;
        state_d = FFN_MAC_IDLE;
      end
    endcase
    out_valid_d = (state_d == FFN_MAC_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FFN_MAC_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q == FFN_MAC_ACC);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int W_LSB = ffn_lane_lsb(i, IN_W);
    localparam int B_LSB = ffn_lane_lsb(i, OUT_W);

    ffn_mac_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .load_i    (first_beat),
      .acc_en_i  (beat),
      .capture_i (last_beat),
      .pixel_i   (bus.feature_pixel),
      .weight_i  (bus.weight[W_LSB +: IN_W]),
      .bias_i    (bus.bias[B_LSB +: OUT_W]),
      .sum_o     (lane_sum[i])
    );
  end

  always_comb begin
    bus.sum_b = '0;
    for (int k = 0; k < LANES; k++) begin
      bus.sum_b[k*OUT_W +: OUT_W] = lane_sum[k];
    end
  end

endmodule

// File: tb/tb_ffn_mac_array.sv
// Bench for ffn_mac_array: three configurations (2 lanes x 4 beats, a narrow
// wrapping lane x 3 beats, single-beat vectors) against a plain-arithmetic model.
module tb_ffn_mac_array;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b, busy_c;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   a_stop = 1'b0;
  logic [63:0] qa[$];

  always #5 clk = ~clk;

  ffn_mac_array_if #(.IN_W(8), .OUT_W(20), .LANES(2)) ifa ();
  ffn_mac_array_if #(.IN_W(4), .OUT_W(8),  .LANES(1)) ifb ();
  ffn_mac_array_if #(.IN_W(8), .OUT_W(16), .LANES(1)) ifc ();

  ffn_mac_array #(.IN_W(8), .OUT_W(20), .LANES(2), .VEC_LEN(4)) dut_a (
    .clock (clk), .reset (rst), .bus (ifa.slave), .busy (busy_a)
  );
  ffn_mac_array #(.IN_W(4), .OUT_W(8), .LANES(1), .VEC_LEN(3)) dut_b (
    .clock (clk), .reset (rst), .bus (ifb.slave), .busy (busy_b)
  );
  ffn_mac_array #(.IN_W(8), .OUT_W(16), .LANES(1), .VEC_LEN(1)) dut_c (
    .clock (clk), .reset (rst), .bus (ifc.slave), .busy (busy_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Exact integer result reduced modulo 2^w, optionally clamped like the ReLU build.
  function automatic logic [63:0] wrap_res(input longint s, input int w);
    logic [63:0] r;
    r = 64'(s) & ((64'd1 << w) - 64'd1);
`ifdef FFN_MAC_RELU_EN
    if (r[w-1]) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [63:0] a_lane(input int l);
    return 64'(ifa.sum_b[l*20 +: 20]);
  endfunction

  task automatic a_beat(input logic [7:0] pix, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [19:0] b0, input logic [19:0] b1);
    logic ok;
    int   t;
    ok = 1'b0;
    t  = 0;
    ifa.feature_pixel = pix;
    ifa.weight        = {w1, w0};
    ifa.bias          = {b1, b0};
    ifa.in_valid      = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = ifa.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    ifa.in_valid      = 1'b0;
    ifa.feature_pixel = 8'($urandom);
    if (!ok) chk("a_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic a_vector(input logic [7:0] p[4], input logic [7:0] w0[4], input logic [7:0] w1[4],
                          input logic [19:0] b0, input logic [19:0] b1, input int gap,
                          input bit release_first, output logic [63:0] e0, output logic [63:0] e1);
    longint s0, s1;
    s0 = longint'($signed(b0));
    s1 = longint'($signed(b1));
    for (int j = 0; j < 4; j++) begin
      s0 += longint'($signed(p[j])) * longint'($signed(w0[j]));
      s1 += longint'($signed(p[j])) * longint'($signed(w1[j]));
      // Bias is only meaningful on the first beat; later beats carry junk.
      if (j == 0) a_beat(p[j], w0[j], w1[j], b0, b1);
      else        a_beat(p[j], w0[j], w1[j], 20'($urandom), 20'($urandom));
      if (j == 0 && release_first) begin
        chk("a_nobubble_valid", 64'(ifa.out_valid), 64'd0);
        ifa.out_ready = 1'b0;
      end
      if (j < 3) begin
        chk("a_busy_beat", 64'(busy_a), 64'd1);
        repeat (gap) begin
          @(posedge clk);
          #1;
          chk("a_busy_gap", 64'(busy_a), 64'd1);
        end
      end
    end
    e0 = wrap_res(s0, 20);
    e1 = wrap_res(s1, 20);
  endtask

  task automatic a_expect(input string tag, input logic [63:0] e0, input logic [63:0] e1);
    chk({tag, "_valid"}, 64'(ifa.out_valid), 64'd1);
    chk({tag, "_lane0"}, a_lane(0), e0);
    chk({tag, "_lane1"}, a_lane(1), e1);
  endtask

  task automatic a_consume();
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.out_ready = 1'b0;
    chk("a_consumed", 64'(ifa.out_valid), 64'd0);
  endtask

  task automatic b_vector(input logic [3:0] p[3], input logic [3:0] w[3], input logic [7:0] b,
                          output logic [63:0] e);
    longint s;
    s = longint'($signed(b));
    for (int j = 0; j < 3; j++) begin
      s += longint'($signed(p[j])) * longint'($signed(w[j]));
      ifb.feature_pixel = p[j];
      ifb.weight        = w[j];
      ifb.bias          = (j == 0) ? b : 8'($urandom);
      ifb.in_valid      = 1'b1;
      @(posedge clk);
      #1;
    end
    ifb.in_valid = 1'b0;
    e = wrap_res(s, 8);
  endtask

  initial begin
    logic [63:0] e0, e1, eb;
    logic [7:0]  rp[4], rw0[4], rw1[4];
    logic [3:0]  bp[3], bw[3];
    logic [7:0]  cp, cw;
    logic [15:0] cb;

    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.feature_pixel = '0; ifa.weight = '0; ifa.bias = '0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.feature_pixel = '0; ifb.weight = '0; ifb.bias = '0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.feature_pixel = '0; ifc.weight = '0; ifc.bias = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_sum", 64'(ifa.sum_b), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_b_valid", 64'(ifb.out_valid), 64'd0);
    chk("rst_c_valid", 64'(ifc.out_valid), 64'd0);

    // Single vector from the test plan, result held under backpressure.
    a_vector('{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd1, 8'd1, 8'd1, 8'd1}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
             20'd10, 20'd0, 0, 1'b0, e0, e1);
    a_expect("a_single", 64'd20, wrap_res(-10, 20));
    chk("a_single_busy", 64'(busy_a), 64'd0);
    chk("a_done_in_ready", 64'(ifa.in_ready), 64'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("a_hold_in_ready", 64'(ifa.in_ready), 64'd0);
      a_expect("a_hold", 64'd20, wrap_res(-10, 20));
    end

    // Result consumed on the same edge as the next vector's first beat.
    ifa.out_ready = 1'b1;
    a_vector('{8'd5, 8'hFD, 8'd4, 8'd7}, '{8'd2, 8'd3, 8'hF9, 8'd1}, '{8'd3, 8'd3, 8'd3, 8'd3},
             20'd7, 20'hFFFFC, 0, 1'b1, e0, e1);
    a_expect("a_nobubble", wrap_res(-13, 20), 64'd35);
    a_consume();

    // Every-other-cycle input gives the same answer.
    a_vector('{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd1, 8'd1, 8'd1, 8'd1}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
             20'd10, 20'd0, 1, 1'b0, e0, e1);
    a_expect("a_stall", 64'd20, wrap_res(-10, 20));
    a_consume();

    // Reset two beats into a vector, then a clean vector.
    a_beat(8'd9, 8'd9, 8'd9, 20'd100, 20'd100);
    a_beat(8'd9, 8'd9, 8'd9, 20'd100, 20'd100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("a_midrst_valid", 64'(ifa.out_valid), 64'd0);
    chk("a_midrst_sum", 64'(ifa.sum_b), 64'd0);
    chk("a_midrst_busy", 64'(busy_a), 64'd0);
    chk("a_midrst_in_ready", 64'(ifa.in_ready), 64'd1);
    for (int j = 0; j < 4; j++) begin
      rp[j] = 8'($urandom); rw0[j] = 8'($urandom); rw1[j] = 8'($urandom);
    end
    a_vector(rp, rw0, rw1, 20'($urandom), 20'($urandom), 0, 1'b0, e0, e1);
    a_expect("a_after_rst", e0, e1);
    a_consume();

    // Narrow lane: accumulator and bias add wrap modulo 2^8.
    b_vector('{4'h8, 4'h8, 4'h8}, '{4'h8, 4'h8, 4'h8}, 8'd0, eb);
    chk("b_wrap_valid", 64'(ifb.out_valid), 64'd1);
    chk("b_wrap_sum", 64'(ifb.sum_b), wrap_res(192, 8));
    for (int v = 0; v < 8; v++) begin
      ifb.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifb.out_ready = 1'b0;
      chk("b_consumed", 64'(ifb.out_valid), 64'd0);
      for (int j = 0; j < 3; j++) begin
        bp[j] = 4'($urandom); bw[j] = 4'($urandom);
      end
      b_vector(bp, bw, 8'($urandom), eb);
      chk("b_rand_valid", 64'(ifb.out_valid), 64'd1);
      chk("b_rand_sum", 64'(ifb.sum_b), eb);
    end

    // Single-beat vectors streamed back to back.
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cp = 8'($urandom); cw = 8'($urandom); cb = 16'($urandom);
      ifc.feature_pixel = cp;
      ifc.weight        = cw;
      ifc.bias          = cb;
      ifc.in_valid      = 1'b1;
      @(posedge clk);
      #1;
      chk("c_valid", 64'(ifc.out_valid), 64'd1);
      chk("c_sum", 64'(ifc.sum_b),
          wrap_res(longint'($signed(cp)) * longint'($signed(cw)) + longint'($signed(cb)), 16));
    end
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("c_drained", 64'(ifc.out_valid), 64'd0);
    chk("c_busy", 64'(busy_c), 64'd0);
    ifc.out_ready = 1'b0;

    // Random traffic with random gaps and random downstream backpressure.
    fork
      begin : producer
        int t;
        for (int v = 0; v < 25; v++) begin
          for (int j = 0; j < 4; j++) begin
            rp[j] = 8'($urandom); rw0[j] = 8'($urandom); rw1[j] = 8'($urandom);
          end
          a_vector(rp, rw0, rw1, 20'($urandom), 20'($urandom), int'($urandom_range(0, 1)),
                   1'b0, e0, e1);
          qa.push_back(e0);
          qa.push_back(e1);
        end
        t = 0;
        while (qa.size() > 0 && t < 500) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("a_rand_drain", 64'(qa.size()), 64'd0);
        a_stop = 1'b1;
      end
      begin : consumer
        int t;
        t = 0;
        while (!a_stop && t < 5000) begin
          ifa.out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (ifa.out_valid) begin
            if (qa.size() < 2) begin
              chk("a_rand_qsize", 64'(qa.size()), 64'd2);
            end else begin
              chk("a_rand_lane0", a_lane(0), qa[0]);
              chk("a_rand_lane1", a_lane(1), qa[1]);
              if (ifa.out_ready) begin
                void'(qa.pop_front());
                void'(qa.pop_front());
              end
            end
          end
          @(posedge clk);
          #1;
          t++;
        end
        ifa.out_ready = 1'b0;
        chk("a_rand_finished", 64'(a_stop), 64'd1);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ffn_mac_array.md
# ffn_mac_array

Parametrised multi-lane multiply-accumulate engine for the fully-connected (FFN) layer. It streams one feature pixel per beat against LANES weights, accumulating LANES dot products over a VEC_LEN-long input vector. It adds a per-lane bias and presents all lane results with a valid/ready handshake. It sits between the FFN feature buffer and the FFN output/activation stage, replacing single-neuron free-running accumulation with counted, framed, back-pressured operation.

## Interface
- IN_W, 24: feature and weight width in bits, signed two's complement.
- OUT_W, 58: accumulator, bias and result width, signed. OUT_W >= 2*IN_W is required; the implementation checks this with an elaboration-time check.
- LANES, 4: number of parallel neurons sharing one feature pixel.
- VEC_LEN, 784: beats per input vector. Must be >= 1.
- CNT_W, $clog2(VEC_LEN+1): beat counter width. Derived; must not be overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  feature/weight beat valid.
- in_ready  out  1  engine can accept a beat.
- feature_pixel  in  IN_W  shared input pixel.
- weight  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W].
- bias  in  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]; sampled on the first beat of a vector.
- out_valid  out  1  sum_b holds a complete result.
- out_ready  in  1  downstream accepts the result.
- sum_b  out  LANES*OUT_W  per-lane dot product plus bias.
- busy  out  1  high in ACC state.

## Operation
- A beat is accepted when in_valid && in_ready.
- FSM states and transitions:
  - IDLE: the first accepted beat clears the accumulators, loads the lane product, latches bias, sets count=1, and moves to ACC. If VEC_LEN==1, it goes directly to DONE.
  - ACC: each accepted beat does acc_i <= acc_i + product_i and count++. The beat that makes count==VEC_LEN moves the FSM to DONE.
  - DONE: sum_b_i = acc_i + bias_i is registered and out_valid=1. The FSM holds until out_ready.
- Handshake:
  - in_ready = (state!=DONE) || out_ready.
  - When DONE, out_ready and an accepted beat coincide, the result is consumed and the beat starts a new vector. This behaves as IDLE-first-beat and moves to ACC (or DONE if VEC_LEN==1).
  - When DONE and out_ready occur with no beat, the FSM returns to IDLE.
- in_valid low in ACC stalls accumulation; count and acc hold. There is no timeout.
- Arithmetic:
  - Each product is a full 2*IN_W signed product, sign-extended to OUT_W.
  - The accumulator and the bias add wrap modulo 2^OUT_W. There is no overflow flag.
- sum_b, once out_valid is high, must not change until the handshake completes.
- Reset, including mid-vector: state=IDLE, count=0, acc=0, latched bias=0, sum_b=0, out_valid=0, busy=0. in_ready=1 in the cycle after reset deasserts. Partial sums are discarded.

## Timing
- Throughput: one beat per cycle. A vector takes VEC_LEN cycles with no stalls.
- Latency: out_valid rises on the clock edge that accepts beat VEC_LEN. sum_b is valid in the next cycle.
- Back-to-back vectors need no bubble when out_ready is high in DONE.
- The multiplier and adder are combinational per lane. The only registers are acc, count, bias, sum_b, state and out_valid.

## Configuration
- FFN_MAC_RELU_EN:
  - Defined: each lane's sum_b is clamped to 0 when acc_i+bias_i is negative (MSB set), before registering. Latency is unchanged.
  - Undefined: the raw wrapped signed sum is output.

## Structure
- The shared package ffn_pkg holds:
  - FFN_IN_W and FFN_OUT_W defaults.
  - The FSM state enum (FFN_MAC_IDLE, FFN_MAC_ACC, FFN_MAC_DONE).
  - Lane-slice helper constants.
- One sub-module, ffn_mac_lane, instantiated LANES times by generate:
  - Contains the signed multiply, sign-extend, accumulate-or-load mux, acc register, bias register, and the output add with optional ReLU.
  - The top level owns the FSM, the counter and the handshake.

## Test plan
- Single vector: LANES=2, VEC_LEN=4, pixels 1,2,3,4, weights lane0=1 and lane1=-1, bias 10/0 -> out_valid after 4th beat, sum_b lane0=20, lane1=-10.
- Backpressure: out_ready low 5 cycles in DONE -> in_ready=0, sum_b stable. Then out_ready with in_valid in the same cycle -> new vector starts with no bubble and acc cleared.
- Input stall: in_valid toggled every other cycle -> identical result; busy high throughout ACC.
- Wrap: IN_W=4, OUT_W=8, pixel=-8, weight=-8, VEC_LEN=3 -> sum_b = 192 mod 256 = 0xC0 (as signed, -64).
- Reset at beat 2 of 4 -> all outputs 0. The next full vector gives the correct sum with no residue.
- With FFN_MAC_RELU_EN: result -10 -> sum_b=0. Without the macro -> sum_b=-10.
